// File: rtl/voting_machine.sv
// voting_machine: four-candidate vote counter with held-button debounce and an 8-bit LED display.
// Optional macro VOTING_TOTAL_DISPLAY_EN: result mode with no button held shows the clamped vote total.
module voting_machine #(
  parameter int HOLD_CYCLES  = 10,
  parameter int FLASH_CYCLES = 10,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode,
  input  logic       button1,
  input  logic       button2,
  input  logic       button3,
  input  logic       button4,
  output logic [7:0] led
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int FLASH_W = $clog2(FLASH_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [3:0]            button_pin;
  logic [3:0]            synced;
  logic [3:0]            valid;
  logic [3:0][CNT_W-1:0] count;
  logic                  mode_reg;
  logic                  mode_change;
  logic                  vote_ok;
  logic [FLASH_W-1:0]    flash_reg;
  logic [7:0]            led_reg;
  logic [7:0]            led_next;

  assign button_pin  = {button4, button3, button2, button1};
  assign mode_change = (mode != mode_reg);
  // A vote counts only when exactly one press matured this cycle.
  assign vote_ok     = !mode && (valid != 4'd0) && ((valid & (valid - 4'd1)) == 4'd0);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_button
      logic              meta_reg;
      logic              sync_reg;
      logic              blocked_reg;
      logic              valid_reg;
      logic [HOLD_W-1:0] hold_reg;
      logic [CNT_W-1:0]  count_reg;

      always_ff @(posedge clock) begin
        if (reset) begin
          meta_reg    <= 1'b0;
          sync_reg    <= 1'b0;
          blocked_reg <= 1'b0;
          valid_reg   <= 1'b0;
          hold_reg    <= '0;
          count_reg   <= '0;
        end else begin
          meta_reg  <= button_pin[gi];
          sync_reg  <= meta_reg;
          valid_reg <= 1'b0;
          if (!sync_reg) begin
            blocked_reg <= 1'b0;
            hold_reg    <= '0;
          end else if (mode_change) begin
            // A press that spans a mode change stays dead until released.
            blocked_reg <= 1'b1;
            hold_reg    <= '0;
          end else if (!blocked_reg && hold_reg < HOLD_W'(HOLD_CYCLES)) begin
            hold_reg  <= hold_reg + 1'b1;
            valid_reg <= (hold_reg == HOLD_W'(HOLD_CYCLES - 1));
          end
          if (vote_ok && valid_reg && count_reg != CNT_MAX)
            count_reg <= count_reg + 1'b1;
        end
      end

      assign synced[gi] = sync_reg;
      assign valid[gi]  = valid_reg;
      assign count[gi]  = count_reg;
    end
  endgenerate

`ifdef VOTING_TOTAL_DISPLAY_EN
  logic [9:0] total;
  assign total = 10'(count[0]) + 10'(count[1]) + 10'(count[2]) + 10'(count[3]);
`endif

  always_comb begin
    led_next = 8'h00;
    if (!mode) begin
      if (flash_reg != '0) led_next = 8'hFF;
    end
    else if (synced[0]) led_next = 8'(count[0]);
    else if (synced[1]) led_next = 8'(count[1]);
    else if (synced[2]) led_next = 8'(count[2]);
    else if (synced[3]) led_next = 8'(count[3]);
`ifdef VOTING_TOTAL_DISPLAY_EN
    else led_next = (total > 10'd255) ? 8'hFF : total[7:0];
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      mode_reg  <= 1'b0;
      flash_reg <= '0;
      led_reg   <= 8'h00;
    end else begin
      mode_reg <= mode;
      if (mode)
        flash_reg <= '0;
      else if (vote_ok)
        flash_reg <= FLASH_W'(FLASH_CYCLES);
      else if (flash_reg != '0)
        flash_reg <= flash_reg - 1'b1;
      led_reg <= led_next;
    end
  end

  assign led = led_reg;

endmodule

// File: tb/tb_voting_machine.sv
// Self-checking bench for voting_machine: directed scenarios plus random presses against a vote-tally model.
module tb_voting_machine;

  localparam int H = 10;
  localparam int F = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       mode;
  logic [3:0] pins;
  logic [7:0] led;

  int passed = 0;
  int total  = 0;
  int cnt[4];

  voting_machine #(.HOLD_CYCLES(H), .FLASH_CYCLES(F), .CNT_W(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .mode    (mode),
    .button1 (pins[0]),
    .button2 (pins[1]),
    .button3 (pins[2]),
    .button4 (pins[3]),
    .led     (led)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
  endtask

  function automatic logic [7:0] idle_led();
    int s;
    s = cnt[0] + cnt[1] + cnt[2] + cnt[3];
`ifdef VOTING_TOTAL_DISPLAY_EN
    return (s > 255) ? 8'hFF : 8'(s);
`else
    return (s < 0) ? 8'hEE : 8'h00;
`endif
  endfunction

  function automatic logic [7:0] result_led(input logic [3:0] mask);
    for (int b = 0; b < 4; b++)
      if (mask[b]) return 8'(cnt[b]);
    return idle_led();
  endfunction

  task automatic set_mode(input logic m);
    mode = m;
    repeat (3) tick();
  endtask

  // Voting-mode press with the LED bank watched cycle by cycle for the flash.
  task automatic press_watch(input logic [3:0] mask, input int len, input string tag);
    int  first;
    int  ffs;
    bit  accepted;
    first = 0;
    ffs   = 0;
    pins  = mask;
    for (int i = 1; i <= len + 30; i++) begin
      tick();
      if (led == 8'hFF) begin
        ffs++;
        if (first == 0) first = i;
      end
      if (i == len) pins = 4'd0;
    end
    accepted = (len >= H) && ($countones(mask) == 1);
    if (accepted)
      for (int b = 0; b < 4; b++)
        if (mask[b] && cnt[b] < 255) cnt[b]++;
    check({tag, "_flash_len"}, 8'(ffs), accepted ? 8'(F) : 8'd0);
    if (accepted) check({tag, "_flash_start"}, 8'(first), 8'(2 + H + 2));
  endtask

  task automatic query(input int b, input string tag);
    pins = 4'd1 << b;
    repeat (4) tick();
    check(tag, led, 8'(cnt[b]));
    pins = 4'd0;
    repeat (4) tick();
  endtask

  task automatic query_all(input string tag);
    for (int b = 0; b < 4; b++) query(b, $sformatf("%s_b%0d", tag, b + 1));
    check({tag, "_idle"}, led, idle_led());
  endtask

  // Result-mode press: the display follows the highest-priority held button and no vote lands.
  task automatic press_result(input logic [3:0] mask, input int len, input string tag);
    pins = mask;
    for (int i = 1; i <= len; i++) begin
      tick();
      if (i == 3) check(tag, led, result_led(mask));
    end
    pins = 4'd0;
    repeat (5) tick();
    check({tag, "_rel"}, led, idle_led());
  endtask

  task automatic fast_vote(input int b);
    pins = 4'd1 << b;
    repeat (H + 2) tick();
    pins = 4'd0;
    repeat (4) tick();
    if (cnt[b] < 255) cnt[b]++;
  endtask

  initial begin
    logic [3:0] mask;
    int         len;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    reset = 1'b1;
    mode  = 1'b0;
    pins  = 4'd0;
    repeat (10) tick();
    check("reset_led", led, 8'h00);
    reset = 1'b0;
    tick();

    set_mode(1'b1);
    query_all("empty");
    set_mode(1'b0);

    press_watch(4'b0001, 1, "short_b1");
    press_watch(4'b0001, 20, "long_b1");
    set_mode(1'b1);
    query(0, "count_b1");
    set_mode(1'b0);

    press_watch(4'b0010, 20, "long_b2");
    press_watch(4'b0110, 20, "dual_b2b3");
    set_mode(1'b1);
    query(1, "after_dual_b2");
    query(2, "after_dual_b3");
    press_result(4'b0100, 20, "hold_b3_result");
    press_result(4'b0110, 6, "prio_b2b3");
    query(2, "no_vote_mode1_b3");

    // Button held while the mode flips back and forth must never vote.
    set_mode(1'b0);
    pins = 4'b0001;
    repeat (5) tick();
    mode = 1'b1;
    repeat (5) tick();
    mode = 1'b0;
    repeat (25) tick();
    check("cross_mode_no_flash", led, 8'h00);
    pins = 4'd0;
    repeat (4) tick();
    set_mode(1'b1);
    query(0, "cross_mode_b1");
    set_mode(1'b0);

    for (int t = 0; t < 30; t++) begin
      mask = 4'($urandom_range(1, 15));
      if ($urandom_range(0, 3) == 0) mask = 4'd1 << $urandom_range(0, 3);
      if ($urandom_range(0, 2) == 0) len = $urandom_range(1, H - 1);
      else len = $urandom_range(H, H + 10);
      if ($urandom_range(0, 4) == 0) begin
        set_mode(1'b1);
        press_result(mask, (len < 3) ? 3 : len, $sformatf("rnd%0d_result", t));
        set_mode(1'b0);
      end else begin
        press_watch(mask, len, $sformatf("rnd%0d", t));
      end
    end
    set_mode(1'b1);
    query_all("rnd_final");
    set_mode(1'b0);

    // Reset lands while the LEDs are flashing.
    pins = 4'b0100;
    repeat (20) tick();
    pins = 4'd0;
    check("flash_before_reset", led, 8'hFF);
    reset = 1'b1;
    tick();
    check("led_after_reset", led, 8'h00);
    reset = 1'b0;
    for (int b = 0; b < 4; b++) cnt[b] = 0;
    tick();
    set_mode(1'b1);
    query_all("post_reset");
    set_mode(1'b0);

    for (int k = 0; k < 256; k++) fast_vote(3);
    set_mode(1'b1);
    query(3, "sat_b4");
    check("sat_idle", led, idle_led());
    query(0, "sat_b1");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
